// File: rtl/nic8_pkg.sv
// rtl/nic8_pkg.sv - shared byte and outport entry types; entry layout depends on FLAG_CAPTURE_EN
package nic8_pkg;

    typedef logic [7:0] byte_t;

`ifdef FLAG_CAPTURE_EN
    typedef struct packed {
        logic  carry;
        byte_t data;
    } outport_entry_t;
`else
    typedef struct packed {
        byte_t data;
    } outport_entry_t;
`endif

    localparam int DEFAULT_OUT_DEPTH = 4;

endpackage

// File: rtl/outport_mem.sv
// rtl/outport_mem.sv - DEPTH-entry register array, one synchronous write port, one asynchronous read port
module outport_mem
    import nic8_pkg::*;
#(
    parameter int DEPTH = DEFAULT_OUT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  outport_entry_t wr_data,
    input  logic [AW-1:0]  rd_addr,
    output outport_entry_t rd_data
);

    outport_entry_t mem_q [DEPTH];
    outport_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // No reset: contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/outport_fifo.sv
// rtl/outport_fifo.sv - first-word fall-through output port queue; FLAG_CAPTURE_EN adds a carry bit per entry
module outport_fifo
    import nic8_pkg::*;
#(
    parameter int DEPTH = DEFAULT_OUT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadBarO,
    input  logic [7:0]             dbus,
    input  logic                   flagCarry,
    input  logic                   outReady,
    output logic                   outValid,
    output logic [7:0]             outData,
    output logic                   outCarry,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic           push_req, push_ok, pop, is_full;
    outport_entry_t wr_entry, rd_entry;

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = dbus;
`ifdef FLAG_CAPTURE_EN
        wr_entry.carry = flagCarry;
`endif
    end

    // A push into a full queue survives only if the head leaves on the same edge.
    always_comb begin
        is_full    = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) && outReady;
        push_req   = !loadBarO;
        push_ok    = push_req && (!is_full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req && !push_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    outport_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok && !reset),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign outValid = (count_q != '0);
    assign outData  = rd_entry.data;
    assign full     = is_full;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef FLAG_CAPTURE_EN
    assign outCarry = rd_entry.carry;
`else
    logic unused_flag_carry;
    assign unused_flag_carry = flagCarry;
    assign outCarry          = 1'b0;
`endif

endmodule

// File: doc/outport_fifo.md
OUTPORT_FIFO -- requirements
Module: outport_fifo

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Port clk, input, 1, single clock; all state SHALL change on posedge clk only.
REQ-003 Port reset, input, 1, reset; synchronous and active-high.
REQ-004 Port loadBarO, input, 1, active-low capture strobe from control decode.
REQ-005 Port dbus, input, 8, data bus value written by the ALU, shifter or registers.
REQ-006 Port flagCarry, input, 1, ALU carry flag, sampled with dbus (used only when FLAG_CAPTURE_EN is defined).
REQ-007 Port outReady, input, 1, consumer accepts the head entry this cycle.
REQ-008 Port outValid, output, 1, head entry present.
REQ-009 Port outData, output, 8, head entry data.
REQ-010 Port outCarry, output, 1, head entry carry (FLAG_CAPTURE_EN only; otherwise tied 0).
REQ-011 Port full, output, 1, count == DEPTH.
REQ-012 Port count, output, $clog2(DEPTH)+1, occupied entries.
REQ-013 Port overflow, output, 1, sticky flag: a capture was dropped.

Function
REQ-014 Push SHALL occur at a posedge where loadBarO==0 and the push is accepted (REQ-018); the entry stores dbus (plus flagCarry under the macro).
REQ-015 Pop SHALL occur at a posedge where outValid && outReady.
REQ-016 First-word fall-through: a pushed entry SHALL be visible on outData/outValid in the cycle after its push edge (latency 1); outData SHALL hold stable while outValid && !outReady.
REQ-017 outValid SHALL equal (count != 0); outData and outCarry are don't-care when outValid==0.
REQ-018 Push when full without a simultaneous pop SHALL be dropped: storage and count are unchanged and overflow is set to 1.
REQ-019 Push and pop at the same edge SHALL both be accepted, including when full: count is unchanged and ordering is preserved.
REQ-020 Pop when empty SHALL be impossible, because outValid==0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-022 overflow SHALL clear only on reset.
REQ-023 dbus SHALL be sampled only when loadBarO==0; high-impedance or unknown dbus while loadBarO==1 SHALL NOT affect any state.

Reset
REQ-024 At a posedge with reset==1: count=0, pointers=0, overflow=0, outValid=0, full=0; storage contents are undefined.
REQ-025 Reset SHALL take priority over a simultaneous push or pop; an in-flight entry is discarded.

Configuration
REQ-026 Macro FLAG_CAPTURE_EN defined: each entry is 9 bits {carry,data}, and outCarry returns the carry captured with that entry.
REQ-027 Macro FLAG_CAPTURE_EN undefined: entries are 8 bits, flagCarry is ignored, and outCarry is constant 0; all other behaviour is identical.

Structure
REQ-028 Shared package nic8_pkg SHALL hold the byte_t (8-bit) typedef, the outport entry typedef (conditional on FLAG_CAPTURE_EN), and the DEFAULT_OUT_DEPTH=4 constant.
REQ-029 Storage SHALL be one sub-module outport_mem: a DEPTH-entry register array with one synchronous write port and one asynchronous read port. Pointer, count and flag logic stay in outport_fifo.

Verification
REQ-030 Reset, then push 0x3C with outReady=0 -> outValid=1 and outData=0x3C on the next cycle; count=1.
REQ-031 DEPTH=4: push 0x01,0x02,0x03,0x04, then 0x05 with outReady=0 -> full=1, count=4, overflow=1; pops return 0x01..0x04 in order, and 0x05 never appears.
REQ-032 Full, then push 0xAA with outReady=1 at the same edge -> count stays 4, overflow stays 0, and 0xAA emerges after 0x02..0x04.
REQ-033 Ten push/pop cycles streaming 0x10..0x19 with outReady=1 -> pointer wrap; the output sequence matches the input, and count toggles only between 0 and 1.
REQ-034 FLAG_CAPTURE_EN defined: push 0xFF with flagCarry=1, then 0x00 with flagCarry=0 -> outCarry=1, then 0 on successive pops. Undefined -> outCarry=0 always.
REQ-035 Assert reset at the same edge as a push while count=3 -> next cycle count=0, outValid=0, overflow=0; dbus=Z with loadBarO=1 for 5 cycles -> no state change.
